// File: rtl/bus_arbiter_rr.sv
// Bus arbiter with fixed-priority or round-robin grant selection, a timed address
// phase awaiting TargetReady, and one-cycle strobe/error completion with a re-request mask.
module bus_arbiter_rr #(
    parameter int N       = 4,
    parameter int MODE    = 1,
    parameter int TIMEOUT = 16,
    localparam int IW     = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [N-1:0]  BARQ,
    output logic [N-1:0]  BAGD,
    output logic [IW-1:0] GrantId,
    output logic          AddressValid,
    input  logic          TargetReady,
    output logic          DataStrobe,
    output logic          Error,
    output logic          Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  bagd_q, bagd_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          addr_valid_q, addr_valid_d;
    logic          data_strobe_q, data_strobe_d;
    logic          error_q, error_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  eligible;
    logic [IW-1:0] win_idx;
    logic          win_found;
    int            idx;

    // Winner selection: MODE 0 keeps the last (highest) eligible index; MODE 1
    // walks from the slot after the previous grant, wrapping at N-1.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        eligible  = BARQ & ~mask_q;
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (eligible[i]) begin
                    win_idx   = IW'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(ptr_q) + k) % N;
                if (!win_found && eligible[idx]) begin
                    win_idx   = IW'(idx);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bagd_d        = bagd_q;
        grant_id_d    = grant_id_q;
        addr_valid_d  = 1'b0;
        data_strobe_d = 1'b0;
        error_d       = 1'b0;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        // A mask bit is released on any edge where its request is low.
        mask_d        = mask_q & BARQ;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d      = S_ADDR;
                    bagd_d       = N'(1) << win_idx;
                    grant_id_d   = win_idx;
                    addr_valid_d = 1'b1;
                    cnt_d        = 8'd0;
                    ptr_d        = win_idx;
                end
            end
            S_ADDR: begin
                cnt_d = cnt_q + 8'd1;
                if (TargetReady) begin
                    state_d       = S_STROBE;
                    data_strobe_d = 1'b1;
                end else if (int'(cnt_q) + 1 >= TIMEOUT) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    addr_valid_d = 1'b1;
                end
            end
            S_STROBE, S_ERR: begin
                state_d    = S_IDLE;
                bagd_d     = '0;
                grant_id_d = '0;
                // Completion sets the owner's mask bit even if its request dropped this edge.
                mask_d     = mask_d | bagd_q;
            end
            default: begin
                state_d    = S_IDLE;
                bagd_d     = '0;
                grant_id_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!clrn) begin
            state_q       <= S_IDLE;
            bagd_q        <= '0;
            grant_id_q    <= '0;
            addr_valid_q  <= 1'b0;
            data_strobe_q <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            mask_q        <= '0;
            cnt_q         <= 8'd0;
            ptr_q         <= IW'(N - 1);
        end else begin
            state_q       <= state_d;
            bagd_q        <= bagd_d;
            grant_id_q    <= grant_id_d;
            addr_valid_q  <= addr_valid_d;
            data_strobe_q <= data_strobe_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
            mask_q        <= mask_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
        end
    end

    assign BAGD         = bagd_q;
    assign GrantId      = grant_id_q;
    assign AddressValid = addr_valid_q;
    assign DataStrobe   = data_strobe_q;
    assign Error        = error_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus; a
// transaction-level model predicts every cycle's outputs and a monitor compares.
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int TO = 4;

    typedef struct packed {
        logic [3:0] bagd;
        logic [1:0] gid;
        logic       av;
        logic       ds;
        logic       err;
        logic       busy;
    } out_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic [3:0] barq;
    logic       tready;

    logic [3:0] rr_bagd, fp_bagd;
    logic [1:0] rr_gid, fp_gid;
    logic       rr_av, rr_ds, rr_err, rr_busy;
    logic       fp_av, fp_ds, fp_err, fp_busy;

    bus_arbiter_rr #(.N(N), .MODE(1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .clrn(clrn), .BARQ(barq), .BAGD(rr_bagd), .GrantId(rr_gid),
        .AddressValid(rr_av), .TargetReady(tready), .DataStrobe(rr_ds),
        .Error(rr_err), .Busy(rr_busy)
    );

    bus_arbiter_rr #(.N(N), .MODE(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .clrn(clrn), .BARQ(barq), .BAGD(fp_bagd), .GrantId(fp_gid),
        .AddressValid(fp_av), .TargetReady(tready), .DataStrobe(fp_ds),
        .Error(fp_err), .Busy(fp_busy)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    out_t exp_rr[$];
    out_t exp_fp[$];

    // Model state per arbiter: 0 idle, 1 address, 2 strobe, 3 error.
    int       m_stage[2];
    int       m_owner[2];
    int       m_wait[2];
    int       m_last[2];
    bit [3:0] m_blk[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int m, input int mode);
        bit [3:0] cand;
        bit [3:0] nblk;
        int       w;
        out_t     e;
        if (!clrn) begin
            m_stage[m] = 0;
            m_owner[m] = -1;
            m_wait[m]  = 0;
            m_last[m]  = N - 1;
            m_blk[m]   = '0;
        end else begin
            cand = barq & ~m_blk[m];
            nblk = m_blk[m] & barq;
            case (m_stage[m])
                0: begin
                    w = -1;
                    if (mode == 0) begin
                        for (int i = N - 1; i >= 0; i--)
                            if (w < 0 && cand[i]) w = i;
                    end else begin
                        for (int d = 1; d <= N; d++) begin
                            int j;
                            j = (m_last[m] + d) % N;
                            if (w < 0 && cand[j]) w = j;
                        end
                    end
                    if (w >= 0) begin
                        m_stage[m] = 1;
                        m_owner[m] = w;
                        m_wait[m]  = 0;
                        m_last[m]  = w;
                    end
                end
                1: begin
                    m_wait[m]++;
                    if (tready) m_stage[m] = 2;
                    else if (m_wait[m] == TO) m_stage[m] = 3;
                end
                default: begin
                    nblk[m_owner[m]] = 1'b1;
                    m_owner[m] = -1;
                    m_stage[m] = 0;
                end
            endcase
            m_blk[m] = nblk;
        end
        e.bagd = (m_owner[m] >= 0) ? 4'(1 << m_owner[m]) : 4'd0;
        e.gid  = (m_owner[m] >= 0) ? 2'(m_owner[m]) : 2'd0;
        e.av   = (m_stage[m] == 1);
        e.ds   = (m_stage[m] == 2);
        e.err  = (m_stage[m] == 3);
        e.busy = (m_stage[m] != 0);
        if (m == 0) exp_rr.push_back(e);
        else        exp_fp.push_back(e);
    endtask

    // Reference model: advances on each rising edge and queues the expected outputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, 1);
            model_step(1, 0);
        end
    end

    // Monitor: compares registered outputs on the falling edge.
    initial begin
        out_t e;
        out_t got;
        @(posedge clk);
        forever begin
            @(negedge clk);
            got = {rr_bagd, rr_gid, rr_av, rr_ds, rr_err, rr_busy};
            if (exp_rr.size() == 0) begin
                tests++; fails++;
                $display("FAIL rr_queue_empty cyc=%0d got=%h exp=entry", cyc, got);
            end else begin
                e = exp_rr.pop_front();
                check("rr_out", 32'(got), 32'(e));
            end
            got = {fp_bagd, fp_gid, fp_av, fp_ds, fp_err, fp_busy};
            if (exp_fp.size() == 0) begin
                tests++; fails++;
                $display("FAIL fp_queue_empty cyc=%0d got=%h exp=entry", cyc, got);
            end else begin
                e = exp_fp.pop_front();
                check("fp_out", 32'(got), 32'(e));
            end
            check("rr_onehot_excl", 32'(($countones(rr_bagd) <= 1) && !(rr_ds && rr_err)), 32'd1);
            check("fp_onehot_excl", 32'(($countones(fp_bagd) <= 1) && !(fp_ds && fp_err)), 32'd1);
        end
    end

    task automatic idle_cycles(input int n);
        barq   = 4'b0000;
        tready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p;
        clrn   = 1'b0;
        barq   = 4'b0000;
        tready = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        // Fixed-priority vs round-robin choice with an immediate target.
        barq   = 4'b0101;
        tready = 1'b1;
        repeat (8) @(negedge clk);

        // All masters requesting; each drops one cycle after its strobe in rr order.
        idle_cycles(3);
        barq = 4'b1111;
        tready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            repeat (3) @(negedge clk);
            barq[g] = 1'b0;
        end
        barq = 4'b1111;
        repeat (4) @(negedge clk);

        // Full timeout.
        idle_cycles(3);
        barq = 4'b1000;
        repeat (8) @(negedge clk);

        // Ready arrives only in the last address cycle.
        idle_cycles(3);
        barq = 4'b0010;
        repeat (4) @(negedge clk);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        // Held request must not be regranted until it drops and returns.
        repeat (6) @(negedge clk);
        barq = 4'b0000;
        @(negedge clk);
        barq = 4'b0010;
        tready = 1'b1;
        repeat (4) @(negedge clk);

        // Reset in the middle of an address phase.
        idle_cycles(3);
        barq = 4'b0100;
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        barq = 4'b1000;
        repeat (4) @(negedge clk);

        // Randomized traffic with varying target responsiveness.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 250) % 3)
                0:       p = 0;
                1:       p = 25;
                default: p = 80;
            endcase
            if ($urandom_range(0, 3) == 0) barq[$urandom_range(0, 3)] ^= 1'b1;
            tready = ($urandom_range(0, 99) < p);
            clrn   = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        clrn = 1'b1;
        idle_cycles(4);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of master devices (legal 2..16).
REQ-002 The block SHALL have parameter MODE, default 1, meaning 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning max address-phase cycles awaiting TargetReady (legal 1..255).
REQ-004 The block SHALL have port clk, input, 1, meaning system clock; all logic on rising edge.
REQ-005 The block SHALL have port clrn, input, 1, meaning reset; one clock, reset synchronous and active-low.
REQ-006 The block SHALL have port BARQ, input, N, meaning per-master bus request, level.
REQ-007 The block SHALL have port BAGD, output, N, meaning bus access granted, one-hot or zero.
REQ-008 The block SHALL have port GrantId, output, max(1,clog2(N)), meaning index of granted master, 0 when idle.
REQ-009 The block SHALL have port AddressValid, output, 1, meaning address phase active, target decode.
REQ-010 The block SHALL have port TargetReady, input, 1, meaning addressed target ready.
REQ-011 The block SHALL have port DataStrobe, output, 1, meaning one-cycle transfer strobe.
REQ-012 The block SHALL have port Error, output, 1, meaning one-cycle timeout indication.
REQ-013 The block SHALL have port Busy, output, 1, meaning state not IDLE.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, STROBE, ERR.
REQ-016 Eligible requests SHALL be BARQ & ~mask, evaluated in IDLE only.
REQ-017 IDLE: eligible nonzero at edge k -> ADDR; BAGD, GrantId and AddressValid valid from cycle k+1 (latency 1).
REQ-018 MODE=0: winner = highest-index eligible bit.
REQ-019 MODE=1: winner = first eligible index searching ptr+1, ptr+2, ... wrapping N-1 -> 0; ptr = last granted index, updated on grant.
REQ-020 ADDR: AddressValid=1, BAGD held; TargetReady=1 sampled -> STROBE; cycle counter increments per ADDR cycle.
REQ-021 ADDR: TIMEOUT ADDR cycles elapsed without TargetReady -> ERR; TargetReady in the final (TIMEOUT-th) cycle -> STROBE (ready wins).
REQ-022 STROBE: DataStrobe=1 exactly one cycle, AddressValid=0, BAGD held; next state IDLE.
REQ-023 ERR: Error=1 exactly one cycle, AddressValid=0, BAGD held; next state IDLE.
REQ-024 On leaving STROBE/ERR, BAGD=0, GrantId=0, and mask bit of the granted master SHALL be set.
REQ-025 Mask bit i SHALL clear on any edge where BARQ[i]=0; set-on-completion takes priority over clear in same cycle.
REQ-026 Minimum transaction = 3 cycles (ADDR, STROBE, IDLE); a new grant SHALL not be issued in the cycle BAGD drops.
REQ-027 BARQ changes during ADDR/STROBE/ERR SHALL not alter BAGD or GrantId.
REQ-028 Counter width SHALL be 8 bits; counter cleared on entry to ADDR; no wrap possible.
REQ-029 DataStrobe and Error SHALL never be high in the same cycle; BAGD SHALL never have more than one bit set.

Reset
REQ-030 clrn=0 at an edge SHALL force state IDLE, BAGD=0, GrantId=0, AddressValid=0, DataStrobe=0, Error=0, Busy=0, mask=0, counter=0, ptr=N-1.
REQ-031 Reset mid-transaction SHALL abort without DataStrobe or Error; first grant after reset in MODE=1 goes to lowest-index eligible master.

Verification
REQ-032 N=4, MODE=0, BARQ=0101 at edge 0, TargetReady=1 -> BAGD=0100, GrantId=2, AddressValid=1 cycle 1; DataStrobe=1 cycle 2; BAGD=0 cycle 3.
REQ-033 N=4, MODE=1, BARQ=1111 held, each master drops BARQ one cycle after its DataStrobe -> grant order 0,1,2,3,0.
REQ-034 TIMEOUT=4, TargetReady=0 -> AddressValid high 4 cycles, Error=1 cycle 5, DataStrobe never, BAGD=0 cycle 6.
REQ-035 TIMEOUT=4, TargetReady=1 only in 4th ADDR cycle -> DataStrobe=1 next cycle, Error stays 0.
REQ-036 Master 1 keeps BARQ=0010 after its strobe -> no regrant until BARQ[1]=0 for at least one edge and reasserted.
REQ-037 clrn=0 during ADDR -> next cycle all outputs 0, no DataStrobe/Error; BARQ=1000 after release (MODE=1) -> BAGD=1000 one cycle later.
